jt12_pg_seq: RTL and testbench



---
 rtl/jt12_pg_seq.sv | 150 +++++++++++++++
 tb/tb_jt12_pg_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/jt12_pg_seq.sv
// Time-multiplexed FM phase generator: increment calc, detune/multiply, per-slot accumulation.
// Optional macro JT12_PG_SAT_EN makes the PM-adjusted fnum saturate instead of wrapping.
module jt12_pg_seq #(
   parameter int SLOTS   = 24,
   parameter int FNUM_W  = 11,
   parameter int PM_W    = 8,
   parameter int PHASE_W = 20,
   parameter int OUT_W   = 10,
   localparam int SW      = $clog2(SLOTS),
   localparam int PHINC_W = FNUM_W + 6
) (
   input  logic              rst,
   input  logic              clk,
   input  logic              clk_en,
   input  logic [2:0]        block,
   input  logic [FNUM_W-1:0] fnum,
   input  logic [PM_W-1:0]   pm_offset,
   input  logic [5:0]        dt_offset,
   input  logic [3:0]        mul,
   input  logic              keyon,
   output logic [SW-1:0]     slot_in,
   output logic [OUT_W-1:0]  phase_out,
   output logic [SW-1:0]     slot_out,
   output logic              out_valid
);

   logic [FNUM_W:0]    fnum_mod;
   logic [PHINC_W-1:0] phinc;

   logic [PHINC_W-1:0] phinc1;
   logic [5:0]         dt1;
   logic [3:0]         mul1;
   logic               key1;
   logic [SW-1:0]      slot1;
   logic               v1;

   logic [PHINC_W-1:0] phd;
   logic [PHASE_W-1:0] phm;

   logic [PHASE_W-1:0] phm2;
   logic               key2;
   logic [SW-1:0]      slot2;
   logic               v2;

   logic [PHASE_W-1:0] mem [SLOTS];
   logic [PHASE_W-1:0] head;
   logic [PHASE_W-1:0] nxt;

`ifdef JT12_PG_SAT_EN
   logic [FNUM_W+2:0] fsum;

   // Two guard bits expose both underflow (sign) and overflow before clamping
   always_comb begin
      fsum = {2'b00, fnum, 1'b0} + {{(FNUM_W+3-PM_W){pm_offset[PM_W-1]}}, pm_offset};
      if (fsum[FNUM_W+2])
         fnum_mod = '0;
      else if (fsum[FNUM_W+1])
         fnum_mod = '1;
      else
         fnum_mod = fsum[FNUM_W:0];
   end
`else
   always_comb begin
      fnum_mod = {fnum, 1'b0} + {{(FNUM_W+1-PM_W){pm_offset[PM_W-1]}}, pm_offset};
   end
`endif

   // (fnum_mod << block) >> 2 without a wider intermediate
   always_comb begin
      if (block >= 3'd2)
         phinc = {5'b00000, fnum_mod} << (block - 3'd2);
      else
         phinc = {5'b00000, fnum_mod} >> (3'd2 - block);
   end

   always_comb begin
      phd = phinc1 + {{(PHINC_W-6){dt1[5]}}, dt1};
      if (mul1 == 4'd0)
         phm = {{(PHASE_W-PHINC_W){1'b0}}, 1'b0, phd[PHINC_W-1:1]};
      else
         phm = {{(PHASE_W-PHINC_W){1'b0}}, phd} * {{(PHASE_W-4){1'b0}}, mul1};
   end

   always_comb begin
      head = mem[SLOTS-1];
      nxt  = key2 ? '0 : head + phm2;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_in <= '0;
      end else if (clk_en) begin
         if (slot_in == SW'(SLOTS-1))
            slot_in <= '0;
         else
            slot_in <= slot_in + SW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phinc1 <= '0;
         dt1    <= '0;
         mul1   <= '0;
         key1   <= 1'b0;
         slot1  <= '0;
         v1     <= 1'b0;
      end else if (clk_en) begin
         phinc1 <= phinc;
         dt1    <= dt_offset;
         mul1   <= mul;
         key1   <= keyon;
         slot1  <= slot_in;
         v1     <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phm2  <= '0;
         key2  <= 1'b0;
         slot2 <= '0;
         v2    <= 1'b0;
      end else if (clk_en) begin
         phm2  <= phm;
         key2  <= key1;
         slot2 <= slot1;
         v2    <= v1;
      end
   end

   // A value pushed at the tail reaches the head exactly SLOTS advances later
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SLOTS; i++)
            mem[i] <= '0;
         phase_out <= '0;
         slot_out  <= '0;
         out_valid <= 1'b0;
      end else if (clk_en) begin
         mem[0] <= nxt;
         for (int i = 1; i < SLOTS; i++)
            mem[i] <= mem[i-1];
         phase_out <= nxt[PHASE_W-1 -: OUT_W];
         slot_out  <= slot2;
         out_valid <= v2;
      end
   end

endmodule

// File: tb/tb_jt12_pg_seq.sv
// Scoreboard bench for jt12_pg_seq: directed vectors carry hand-computed per-frame increments.
module tb_jt12_pg_seq;
   localparam int SLOTS = 24;

   logic        rst, clk, clk_en;
   logic [2:0]  block;
   logic [10:0] fnum;
   logic [7:0]  pm_offset;
   logic [5:0]  dt_offset;
   logic [3:0]  mul;
   logic        keyon;
   logic [4:0]  slot_in, slot_out;
   logic [9:0]  phase_out;
   logic        out_valid;

   int          tests = 0;
   int          fails = 0;
   int          tbSlot = 0;
   int          enCount = 0;
   logic [14:0] sbq [$];
   logic [19:0] expAcc [SLOTS];

   jt12_pg_seq dut (
      .rst(rst), .clk(clk), .clk_en(clk_en), .block(block), .fnum(fnum),
      .pm_offset(pm_offset), .dt_offset(dt_offset), .mul(mul), .keyon(keyon),
      .slot_in(slot_in), .phase_out(phase_out), .slot_out(slot_out), .out_valid(out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one slot sample and pushes the phase this slot must show three advances later
   task automatic applyStimulus(input logic [2:0] b, input logic [10:0] f, input logic [7:0] pm,
                                input logic [5:0] dt, input logic [3:0] m, input logic ko,
                                input logic [19:0] inc);
      @(negedge clk);
      clk_en = 1'b1; block = b; fnum = f; pm_offset = pm; dt_offset = dt; mul = m; keyon = ko;
      checkOutput("slot_in", 32'(slot_in), 32'(tbSlot));
      expAcc[tbSlot] = ko ? 20'd0 : expAcc[tbSlot] + inc;
      sbq.push_back({5'(tbSlot), expAcc[tbSlot][19:10]});
      tbSlot = (tbSlot == SLOTS-1) ? 0 : tbSlot + 1;
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst = 1'b1; clk_en = 1'b0; keyon = 1'b0;
      sbq.delete();
      for (int i = 0; i < SLOTS; i++) expAcc[i] = 20'd0;
      tbSlot = 0;
      #1;
      checkOutput("rst slot_in", 32'(slot_in), 32'd0);
      checkOutput("rst slot_out", 32'(slot_out), 32'd0);
      checkOutput("rst phase_out", 32'(phase_out), 32'd0);
      checkOutput("rst out_valid", 32'(out_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic stallCycles(input int n);
      logic [20:0] snap;
      @(negedge clk);
      clk_en = 1'b0; keyon = 1'b1; fnum = 11'h7FF; block = 3'd7; mul = 4'd9; dt_offset = 6'h15;
      snap = {slot_in, slot_out, phase_out, out_valid};
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         checkOutput("stall hold", 32'({slot_in, slot_out, phase_out, out_valid}), 32'(snap));
      end
      keyon = 1'b0;
   endtask

   // Monitor: every advance after reset checks out_valid timing and pops the scoreboard
   initial begin
      logic        enS;
      logic [14:0] e;
      forever begin
         @(posedge clk);
         enS = clk_en;
         #1;
         if (rst) begin
            enCount = 0;
         end else if (enS) begin
            enCount++;
            checkOutput("out_valid", 32'(out_valid), 32'(enCount >= 3));
            if (out_valid) begin
               if (sbq.size() == 0) begin
                  tests++;
                  fails++;
                  $display("[TB] FAIL scoreboard: output slot %0d with no expected entry", slot_out);
               end else begin
                  e = sbq.pop_front();
                  checkOutput("slot_out", 32'(slot_out), 32'(e[14:10]));
                  checkOutput("phase_out", 32'(phase_out), 32'(e[9:0]));
               end
            end
         end
      end
   end

   initial begin
      logic [3:0]  mulTab [4];
      logic [19:0] incTab [4];
      logic [19:0] pmInc;
      mulTab = '{4'd0, 4'd1, 4'd15, 4'd3};
      incTab = '{20'h00800, 20'h01000, 20'h0F000, 20'h03000};
`ifdef JT12_PG_SAT_EN
      pmInc = 20'h00000;
`else
      pmInc = 20'h00FFF;
`endif
      rst = 1'b1; clk_en = 1'b0; block = '0; fnum = '0; pm_offset = '0;
      dt_offset = '0; mul = '0; keyon = 1'b0;
      applyReset();

      $display("[TB] basic increment, 0x1000 per frame through 256-frame wrap");
      for (int f = 0; f < 258; f++)
         for (int s = 0; s < SLOTS; s++) begin
            if (f == 3 && s == 10) stallCycles(10);
            applyStimulus(3'd4, 11'h200, 8'h00, 6'h00, 4'd1, 1'b0, 20'h01000);
         end

      $display("[TB] multiplier isolation");
      for (int f = 0; f < 4; f++)
         for (int s = 0; s < SLOTS; s++)
            applyStimulus(3'd4, 11'h200, 8'h00, 6'h00, mulTab[s % 4], 1'b0, incTab[s % 4]);

      $display("[TB] key-on");
      for (int f = 0; f < 3; f++)
         for (int s = 0; s < SLOTS; s++) begin
            if (f == 1 && s == 5)
               applyStimulus(3'd4, 11'h200, 8'h00, 6'h00, 4'd1, 1'b1, 20'h01000);
            else if (f == 1 && s == 6)
               applyStimulus(3'd4, 11'h200, 8'h00, 6'h00, 4'd15, 1'b1, 20'h0F000);
            else
               applyStimulus(3'd4, 11'h200, 8'h00, 6'h00, 4'd1, 1'b0, 20'h01000);
         end

      $display("[TB] mid-frame reset then PM underflow");
      for (int s = 0; s < 7; s++)
         applyStimulus(3'd4, 11'h200, 8'h00, 6'h00, 4'd1, 1'b0, 20'h01000);
      applyReset();
      for (int f = 0; f < 3; f++)
         for (int s = 0; s < SLOTS; s++)
            applyStimulus(3'd2, 11'h000, 8'hFF, 6'h00, 4'd1, 1'b0, pmInc);

      $display("[TB] detune wrap");
      for (int f = 0; f < 3; f++)
         for (int s = 0; s < SLOTS; s++)
            applyStimulus(3'd0, 11'h006, 8'h00, 6'h3C, 4'd1, 1'b0, 20'h1FFFF);

      $display("[TB] second reset, restart from slot 0");
      for (int s = 0; s < 5; s++)
         applyStimulus(3'd4, 11'h200, 8'h00, 6'h00, 4'd1, 1'b0, 20'h01000);
      applyReset();
      for (int s = 0; s < SLOTS + 3; s++)
         applyStimulus(3'd4, 11'h200, 8'h00, 6'h00, 4'd2, 1'b0, 20'h02000);

      @(negedge clk);
      clk_en = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
